psc_trigger_scheduler: RTL and testbench
========================================

PSC_TRIGGER_SCHEDULER -- requirements
Module: psc_trigger_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of trigger requesters.
REQ-002 Parameter FRAME_LEN, default 10: cycles per TX frame slot.
REQ-003 Parameter DELAY_W, default 8: width of the frame-delay setting.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  scheduler enable; the frame counter is unaffected.
REQ-007 req  in  N_REQ  per-requester trigger request, sampled every cycle.
REQ-008 delay  in  DELAY_W  whole frames to wait after grant before firing, sampled in GRANT.
REQ-009 trigger_pulse  out  1  single-cycle trigger to the downstream trigger FSM.
REQ-010 grant  out  N_REQ  one-hot ID of the requester in service; zero otherwise.
REQ-011 frame_cnt  out  4  free-running slot counter 0..FRAME_LEN-1.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 drop_count  out  8  saturating count of requests rejected as duplicates.

Function
REQ-014 frame_cnt SHALL increment every cycle and wrap from FRAME_LEN-1 to 0; "frame end" (FE) means frame_cnt==FRAME_LEN-1.
REQ-015 Pending: req[i]=1 SHALL set pending[i]; GRANT of i SHALL clear pending[i]; if set and clear coincide, set wins.
REQ-016 req[i]=1 while pending[i]=1 already, or while grant[i]=1, SHALL increment drop_count (saturating at 255) and SHALL leave pending[i] set.
REQ-017 Simultaneous drops from several requesters in one cycle SHALL increment drop_count by 1 only.
REQ-018 States: IDLE, GRANT, WAIT, FIRE, HOLD; one state per cycle, registered.
REQ-019 IDLE -> GRANT when enable=1 and pending!=0; otherwise stay in IDLE.
REQ-020 GRANT (1 cycle): select round-robin, searching from index (last+1) mod N_REQ upward with wrap; drive grant one-hot from the next cycle; clear the pending bit; set last to the winner; load dcnt with delay; go to WAIT.
REQ-021 WAIT: at each FE, if dcnt==0 go to FIRE, else decrement dcnt; no action on non-FE cycles.
REQ-022 Consequence: FIRE SHALL coincide with frame_cnt==0 and SHALL occur at the (delay+1)th frame start after leaving GRANT.
REQ-023 FIRE (1 cycle): trigger_pulse=1; go to HOLD.
REQ-024 HOLD SHALL last until the second FE after FIRE, i.e. exactly 2*FRAME_LEN-1 cycles; then go to IDLE and clear grant.
REQ-025 trigger_pulse SHALL be high only in FIRE, exactly one cycle per grant.
REQ-026 grant SHALL be held constant from GRANT+1 through the last HOLD cycle.
REQ-027 enable=0 in GRANT, WAIT, FIRE or HOLD SHALL return the state to IDLE next cycle, clear grant, and emit no pulse. The aborted requester's pending bit SHALL stay cleared; last SHALL keep the winner.
REQ-028 enable=0 in IDLE SHALL block arbitration; pending bits SHALL keep accumulating.
REQ-029 With delay at its maximum value, dcnt arithmetic SHALL NOT wrap; decrement occurs only when dcnt>0.

Reset
REQ-030 With reset=1 at a clock edge: state=IDLE, frame_cnt=0, pending=0, dcnt=0, last=N_REQ-1, grant=0, trigger_pulse=0, busy=0, drop_count=0.
REQ-031 Reset SHALL override all other inputs. Reset asserted mid-service SHALL abort without a pulse; pending requests SHALL be discarded.
REQ-032 After reset is released, frame_cnt SHALL read 1 on the first active edge.

Verification
REQ-033 Basic fire: reset, enable=1, delay=0, one-cycle req=0001 at frame_cnt=3 -> grant=0001; trigger_pulse exactly once, at the next frame_cnt==0; busy drops 2*FRAME_LEN-1 cycles after the pulse.
REQ-034 Delay: delay=2, req=0100 -> the pulse occurs at the third frame start after GRANT, with frame_cnt==0 at the pulse.
REQ-035 Round-robin: req=1111 for one cycle after reset -> grants 0001, 0010, 0100, 1000 in order, one pulse each, and drop_count=0.
REQ-036 Duplicates: req=0010 held for 5 cycles while idle -> drop_count=4; after a further 260 duplicates, drop_count holds at 255.
REQ-037 Abort: enable dropped for 1 cycle during WAIT -> IDLE next cycle, grant=0, no trigger_pulse. A later request from the same requester is then serviced normally.
REQ-038 Reset mid-HOLD -> all outputs take their REQ-030 values on the next edge, and frame_cnt restarts from 0.

Source files
------------

// File: rtl/psc_trigger_scheduler.sv
// ---------------------------------------------------------------------------
// psc_trigger_scheduler
//
// Purpose: arbitrates trigger requests from N_REQ requesters round-robin,
// waits a programmable number of whole TX frames after granting, then emits a
// single-cycle trigger pulse aligned to a frame start. After the pulse, the
// grant is held for two frame ends before the scheduler returns to idle.
//
// Ports:
//   i_clk           - single clock, rising edge
//   i_reset         - synchronous active-high reset
//   i_enable        - scheduler enable (frame counter keeps running)
//   i_req           - per-requester trigger request, sampled every cycle
//   i_delay         - whole frames to wait after grant, sampled in GRANT
//   o_trigger_pulse - one-cycle trigger to the downstream trigger FSM
//   o_grant         - one-hot ID of the requester in service, else zero
//   o_frame_cnt     - free-running slot counter 0..FRAME_LEN-1
//   o_busy          - high whenever the scheduler is not idle
//   o_drop_count    - saturating count of cycles with duplicate requests
// ---------------------------------------------------------------------------
module psc_trigger_scheduler #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 10,
  parameter int DELAY_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [DELAY_W-1:0] i_delay,
  output logic               o_trigger_pulse,
  output logic [N_REQ-1:0]   o_grant,
  output logic [3:0]         o_frame_cnt,
  output logic               o_busy,
  output logic [7:0]         o_drop_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_FIRE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [3:0]       FE_VAL   = 4'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [2:0]         r_state;
  logic [3:0]         r_frame_cnt;
  logic [N_REQ-1:0]   r_pending;
  logic [IDX_W-1:0]   r_last;
  logic [DELAY_W-1:0] r_dcnt;
  logic               r_fe_seen;
  logic [N_REQ-1:0]   r_grant;
  logic               r_trigger;
  logic               r_busy;
  logic [7:0]         r_drop_count;

  logic               w_fe;
  logic [2:0]         w_state_nxt;
  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_probe;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [N_REQ-1:0]   w_clear;
  logic [N_REQ-1:0]   w_drop_vec;

  assign w_fe       = (r_frame_cnt == FE_VAL);
  // A request is a duplicate when that requester is already queued or in service.
  assign w_drop_vec = i_req & (r_pending | r_grant);
  assign w_clear    = ((r_state == S_GRANT) && w_win_valid) ? w_win_onehot : {N_REQ{1'b0}};

  // Round-robin pick: first pending requester at or after (last+1), wrapping.
  always_comb begin
    w_win_valid  = 1'b0;
    w_win_idx    = r_last;
    w_probe      = r_last;
    w_win_onehot = {N_REQ{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      w_probe = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_win_valid && r_pending[w_probe]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_probe;
      end else begin
        w_win_idx   = w_win_idx;
      end
    end
    if (w_win_valid) begin
      w_win_onehot = N_REQ'(1'b1) << w_win_idx;
    end else begin
      w_win_onehot = {N_REQ{1'b0}};
    end
  end

  // Next-state decode; dropping enable aborts any service back to idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (r_pending != {N_REQ{1'b0}})) w_state_nxt = S_GRANT;
        else                                           w_state_nxt = S_IDLE;
      end
      S_GRANT: begin
        if (i_enable && w_win_valid) w_state_nxt = S_WAIT;
        else                         w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (!i_enable)                                   w_state_nxt = S_IDLE;
        else if (w_fe && (r_dcnt == {DELAY_W{1'b0}}))    w_state_nxt = S_FIRE;
        else                                             w_state_nxt = S_WAIT;
      end
      S_FIRE: begin
        if (!i_enable) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // The FIRE cycle sits at frame 0, so the second frame end is one
        // cycle short of two full frames later.
        if (!i_enable)             w_state_nxt = S_IDLE;
        else if (w_fe && r_fe_seen) w_state_nxt = S_IDLE;
        else                        w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Free-running frame slot counter, independent of enable.
  always_ff @(posedge i_clk) begin
    if (i_reset)   r_frame_cnt <= 4'd0;
    else if (w_fe) r_frame_cnt <= 4'd0;
    else           r_frame_cnt <= r_frame_cnt + 4'd1;
  end

  // Pending request bits (a new request beats a same-cycle grant clear) and
  // the saturating duplicate counter, which counts at most one per cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending    <= {N_REQ{1'b0}};
      r_drop_count <= 8'd0;
    end else begin
      r_pending <= i_req | (r_pending & ~w_clear);
      if ((w_drop_vec != {N_REQ{1'b0}}) && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end else begin
        r_drop_count <= r_drop_count;
      end
    end
  end

  // State register, arbitration history, frame delay counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_last    <= LAST_RST;
      r_dcnt    <= {DELAY_W{1'b0}};
      r_fe_seen <= 1'b0;
      r_grant   <= {N_REQ{1'b0}};
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_trigger <= (w_state_nxt == S_FIRE);
      r_busy    <= (w_state_nxt != S_IDLE);

      // The winner is committed even if enable drops during GRANT.
      if ((r_state == S_GRANT) && w_win_valid) r_last <= w_win_idx;

      // Decrement only above zero so a maximal delay cannot wrap.
      if (r_state == S_GRANT) begin
        r_dcnt <= i_delay;
      end else if ((r_state == S_WAIT) && w_fe && (r_dcnt != {DELAY_W{1'b0}})) begin
        r_dcnt <= r_dcnt - DELAY_W'(1);
      end

      if (r_state == S_FIRE)                r_fe_seen <= 1'b0;
      else if ((r_state == S_HOLD) && w_fe) r_fe_seen <= 1'b1;

      if (w_state_nxt == S_IDLE)    r_grant <= {N_REQ{1'b0}};
      else if (r_state == S_GRANT)  r_grant <= w_win_onehot;
    end
  end

  assign o_trigger_pulse = r_trigger;
  assign o_grant         = r_grant;
  assign o_frame_cnt     = r_frame_cnt;
  assign o_busy          = r_busy;
  assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_psc_trigger_scheduler.sv
// ---------------------------------------------------------------------------
// tb_psc_trigger_scheduler
//
// Directed stimulus with hand-computed pulse times. Each expected trigger
// (grant and the cycle it must appear in) is queued when the request is
// issued; a separate monitor pops an entry whenever trigger_pulse is seen and
// also checks the HOLD length and grant stability after each pulse.
// ---------------------------------------------------------------------------
module tb_psc_trigger_scheduler;

  localparam int FL = 10;

  typedef struct {
    logic [3:0] grant;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'd0;
  logic [7:0] dly = 8'd0;

  logic       trig;
  logic [3:0] grant;
  logic [3:0] fcnt;
  logic       busy;
  logic [7:0] drops;

  int   cyc     = 0;
  int   rst_cnt = 0;
  int   m_frame = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  exp_t sb_q[$];

  psc_trigger_scheduler #(.N_REQ(4), .FRAME_LEN(FL), .DELAY_W(8)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_req           (req),
    .i_delay         (dly),
    .o_trigger_pulse (trig),
    .o_grant         (grant),
    .o_frame_cnt     (fcnt),
    .o_busy          (busy),
    .o_drop_count    (drops)
  );

  always #5 clk = ~clk;

  // Cycle count, reset count and the bench's own view of the frame slot.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rst_cnt <= rst_cnt + 1;
      m_frame <= 0;
    end else begin
      m_frame <= (m_frame == FL - 1) ? 0 : m_frame + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_frame(input int f);
    repeat (2 * FL) begin
      if (m_frame == f) break;
      @(negedge clk);
    end
    if (m_frame != f) check("frame_align", 32'(m_frame), 32'(f));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    @(negedge clk);
    check("rst_trigger", 32'(trig),  32'd0);
    check("rst_grant",   32'(grant), 32'd0);
    check("rst_frame",   32'(fcnt),  32'd0);
    check("rst_busy",    32'(busy),  32'd0);
    check("rst_drops",   32'(drops), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("frame_after_rst", 32'(fcnt), 32'd1);
  endtask

  // Request at frame slot 3; pulse expected off cycles after the request cycle.
  task automatic issue(input logic [3:0] r, input logic [3:0] g, input int off);
    exp_t e;
    wait_frame(3);
    req = r;
    if (g != 4'd0) begin
      e.grant = g;
      e.cyc   = cyc + off;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req = 4'd0;
  endtask

  task automatic push_exp(input logic [3:0] g, input int at);
    exp_t e;
    e.grant = g;
    e.cyc   = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    repeat (400) begin
      @(negedge clk);
      if (!busy) quiet++;
      else       quiet = 0;
      if (quiet >= 3) break;
    end
    check("idle_reached", 32'(quiet >= 3), 32'd1);
  endtask

  // Monitor: pops one expectation per trigger pulse, then measures HOLD.
  initial begin
    exp_t e;
    int   hold_n;
    int   r0;
    logic grant_ok;
    forever begin
      @(negedge clk);
      if (trig === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'(trig), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_grant", 32'(grant), 32'(e.grant));
          check("pulse_frame", 32'(fcnt),  32'd0);
          check("pulse_cycle", 32'(cyc),   32'(e.cyc));
          r0       = rst_cnt;
          hold_n   = 0;
          grant_ok = 1'b1;
          for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy || (rst_cnt != r0)) break;
            hold_n++;
            if (grant !== e.grant) grant_ok = 1'b0;
          end
          if (rst_cnt == r0) begin
            check("hold_len",   32'(hold_n),   32'(2 * FL - 1));
            check("hold_grant", 32'(grant_ok), 32'd1);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int c;

    do_reset();
    en = 1'b1;

    // Basic fire: delay 0, request at slot 3 -> pulse 7 cycles later at slot 0.
    dly = 8'd0;
    issue(4'b0001, 4'b0001, 7);
    wait_idle();
    check("drops_basic", 32'(drops), 32'd0);

    // Delay of 2 frames: two more frames after the first frame start.
    dly = 8'd2;
    issue(4'b0100, 4'b0100, 27);
    wait_idle();

    // Round robin from reset: each service takes 30 cycles end to end.
    do_reset();
    en  = 1'b1;
    dly = 8'd0;
    wait_frame(3);
    c   = cyc;
    req = 4'b1111;
    push_exp(4'b0001, c + 7);
    push_exp(4'b0010, c + 37);
    push_exp(4'b0100, c + 67);
    push_exp(4'b1000, c + 97);
    @(negedge clk);
    req = 4'd0;
    wait_idle();
    check("drops_rr", 32'(drops), 32'd0);

    // Duplicates while arbitration is blocked, then saturation.
    do_reset();
    en  = 1'b0;
    req = 4'b0010;
    repeat (5) @(negedge clk);
    req = 4'd0;
    check("drops_4", 32'(drops), 32'd4);
    req = 4'b0010;
    repeat (260) @(negedge clk);
    req = 4'd0;
    check("drops_sat", 32'(drops), 32'd255);
    @(negedge clk);
    check("drops_hold", 32'(drops), 32'd255);
    // The queued request is serviced once arbitration is re-enabled.
    wait_frame(3);
    en = 1'b1;
    push_exp(4'b0010, cyc + 7);
    wait_idle();

    // Abort during WAIT: no pulse, idle and grant clear next cycle.
    dly = 8'd2;
    wait_frame(3);
    c   = cyc;
    req = 4'b1000;
    @(negedge clk);
    req = 4'd0;
    repeat (9) @(negedge clk);
    check("abort_pre_busy",  32'(busy),  32'd1);
    check("abort_pre_grant", 32'(grant), 32'd8);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    repeat (40) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    dly = 8'd0;
    issue(4'b1000, 4'b1000, 7);
    wait_idle();

    // Reset in the middle of HOLD, with another request queued.
    issue(4'b0001, 4'b0001, 7);
    repeat (8) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'd0;
    @(negedge clk);
    check("hold_busy_pre_rst", 32'(busy), 32'd1);
    do_reset();
    repeat (40) @(negedge clk);
    check("rst_discards_pending", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
